// File: rtl/multi_debounce_pulse.sv
// N-channel pushbutton conditioner: 2-flop sync, tick-sampled stable-count debounce, press/release pulses.
// Optional auto-repeat of the press pulse is built when DEBOUNCE_AUTOREPEAT_EN is defined.
`timescale 1ns/1ps
module multi_debounce_pulse #(
  parameter int N_BTN        = 5,
  parameter int TICK_DIV     = 100000,
  parameter int STABLE_CNT   = 4,
  parameter int REPEAT_DELAY = 500,
  parameter int REPEAT_RATE  = 100
) (
  input  logic             CLOCK,
  input  logic             RESET_N,
  input  logic [N_BTN-1:0] PUSHBUTTON,
  output logic [N_BTN-1:0] LEVEL,
  output logic [N_BTN-1:0] SINGLE_PULSE,
  output logic [N_BTN-1:0] RELEASE_PULSE,
  output logic             SAMPLE_TICK
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int CW = $clog2(STABLE_CNT + 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [CW-1:0] CNT_DONE  = CW'(STABLE_CNT);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO  = {CW{1'b0}};

  typedef enum logic [1:0] {
    ST_LOW          = 2'd0,
    ST_CONFIRM_HIGH = 2'd1,
    ST_HIGH         = 2'd2,
    ST_CONFIRM_LOW  = 2'd3
  } state_e;

  logic [N_BTN-1:0] sync1_q, sync2_q;
  logic [TW-1:0]    tick_cnt_q, tick_cnt_d;
  logic             tick_q, tick_d;
  state_e           state_q [N_BTN];
  state_e           state_d [N_BTN];
  logic [CW-1:0]    cnt_q [N_BTN];
  logic [CW-1:0]    cnt_d [N_BTN];
  logic [N_BTN-1:0] level_q, level_d, press_q, press_d, rel_q, rel_d;
  logic [N_BTN-1:0] rep_fire_s;

  // Tick is registered so it reads 0 in reset; it is high while the counter sits at TICK_DIV-1.
  always_comb begin
    if (tick_cnt_q == TICK_LAST) begin
      tick_cnt_d = {TW{1'b0}};
    end else begin
      tick_cnt_d = tick_cnt_q + TW'(1);
    end
    tick_d = (tick_cnt_d == TICK_LAST);
  end

  // Per-channel debounce FSM, advanced only on sample ticks.
  always_comb begin
    for (int i = 0; i < N_BTN; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      if (tick_q) begin
        case (state_q[i])
          ST_LOW: begin
            if (sync2_q[i]) begin
              cnt_d[i]   = CNT_ONE;
              state_d[i] = (STABLE_CNT == 1) ? ST_HIGH : ST_CONFIRM_HIGH;
            end else begin
              cnt_d[i] = CNT_ZERO;
            end
          end
          ST_CONFIRM_HIGH: begin
            if (sync2_q[i]) begin
              cnt_d[i] = cnt_q[i] + CNT_ONE;
              if (cnt_q[i] + CNT_ONE == CNT_DONE) begin
                state_d[i] = ST_HIGH;
              end else begin
                state_d[i] = ST_CONFIRM_HIGH;
              end
            end else begin
              cnt_d[i]   = CNT_ZERO;
              state_d[i] = ST_LOW;
            end
          end
          ST_HIGH: begin
            if (!sync2_q[i]) begin
              cnt_d[i]   = CNT_ONE;
              state_d[i] = (STABLE_CNT == 1) ? ST_LOW : ST_CONFIRM_LOW;
            end else begin
              cnt_d[i] = CNT_ZERO;
            end
          end
          ST_CONFIRM_LOW: begin
            if (!sync2_q[i]) begin
              cnt_d[i] = cnt_q[i] + CNT_ONE;
              if (cnt_q[i] + CNT_ONE == CNT_DONE) begin
                state_d[i] = ST_LOW;
              end else begin
                state_d[i] = ST_CONFIRM_LOW;
              end
            end else begin
              cnt_d[i]   = CNT_ZERO;
              state_d[i] = ST_HIGH;
            end
          end
          default: begin
            cnt_d[i]   = CNT_ZERO;
            state_d[i] = ST_LOW;
          end
        endcase
      end else begin
        state_d[i] = state_q[i];
      end
      level_d[i] = (state_d[i] == ST_HIGH) || (state_d[i] == ST_CONFIRM_LOW);
    end
  end

`ifdef DEBOUNCE_AUTOREPEAT_EN
  localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RW   = $clog2(RMAX + 1);
  localparam logic [RW-1:0] REP_DELAY_V = RW'(REPEAT_DELAY);
  localparam logic [RW-1:0] REP_RATE_V  = RW'(REPEAT_RATE);

  logic [RW-1:0]    rep_cnt_q [N_BTN];
  logic [RW-1:0]    rep_cnt_d [N_BTN];
  logic [N_BTN-1:0] rep_first_q, rep_first_d;

  // Repeat timer restarts on the press; fires only while the level stays high, so never with a release.
  always_comb begin
    for (int i = 0; i < N_BTN; i++) begin
      rep_cnt_d[i]   = rep_cnt_q[i];
      rep_first_d[i] = rep_first_q[i];
      rep_fire_s[i]  = 1'b0;
      if (level_d[i] && !level_q[i]) begin
        rep_cnt_d[i]   = {RW{1'b0}};
        rep_first_d[i] = 1'b1;
      end else if (tick_q && level_d[i] && level_q[i]) begin
        if (rep_cnt_q[i] + RW'(1) == (rep_first_q[i] ? REP_DELAY_V : REP_RATE_V)) begin
          rep_fire_s[i]  = 1'b1;
          rep_cnt_d[i]   = {RW{1'b0}};
          rep_first_d[i] = 1'b0;
        end else begin
          rep_cnt_d[i] = rep_cnt_q[i] + RW'(1);
        end
      end else begin
        rep_fire_s[i] = 1'b0;
      end
    end
  end

  // Repeat timer state.
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int i = 0; i < N_BTN; i++) begin
        rep_cnt_q[i] <= {RW{1'b0}};
      end
      rep_first_q <= {N_BTN{1'b0}};
    end else begin
      rep_cnt_q   <= rep_cnt_d;
      rep_first_q <= rep_first_d;
    end
  end
`else
  logic rep_unused_s;
  assign rep_unused_s = (REPEAT_DELAY > REPEAT_RATE);
  assign rep_fire_s   = {N_BTN{1'b0}};
`endif

  // Pulses are derived from the next level so they line up with the registered LEVEL edge.
  always_comb begin
    press_d = (level_d & ~level_q) | rep_fire_s;
    rel_d   = ~level_d & level_q;
  end

  // Synchronisers, tick counter, channel state and registered outputs.
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      sync1_q    <= {N_BTN{1'b0}};
      sync2_q    <= {N_BTN{1'b0}};
      tick_cnt_q <= {TW{1'b0}};
      tick_q     <= 1'b0;
      for (int i = 0; i < N_BTN; i++) begin
        state_q[i] <= ST_LOW;
        cnt_q[i]   <= CNT_ZERO;
      end
      level_q <= {N_BTN{1'b0}};
      press_q <= {N_BTN{1'b0}};
      rel_q   <= {N_BTN{1'b0}};
    end else begin
      sync1_q    <= PUSHBUTTON;
      sync2_q    <= sync1_q;
      tick_cnt_q <= tick_cnt_d;
      tick_q     <= tick_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      level_q    <= level_d;
      press_q    <= press_d;
      rel_q      <= rel_d;
    end
  end

  assign LEVEL         = level_q;
  assign SINGLE_PULSE  = press_q;
  assign RELEASE_PULSE = rel_q;
  assign SAMPLE_TICK   = tick_q;

endmodule

// File: doc/multi_debounce_pulse.md
Name: multi_debounce_pulse

Overview:
Parametrised N-channel pushbutton conditioner that replaces the slow-clock flip-flop pulse scheme.
- Each raw button is synchronised into CLOCK, filtered by a sampled stable-count debouncer, and produces a debounced level plus one-CLOCK-cycle press and release pulses.
- All logic runs on CLOCK; the sample rate is set by an internal enable tick, so no derived clocks are used.
- Sits between the board pushbuttons and the menu/game FSMs.

Parameters:
- N_BTN, 5, number of independent button channels (>=1).
- TICK_DIV, 100000, CLOCK cycles per sample tick (>=1); 1 ms at 100 MHz.
- STABLE_CNT, 4, consecutive ticks a new value must hold before LEVEL changes (>=1).
- REPEAT_DELAY, 500, ticks from press pulse to first auto-repeat pulse (used only with the optional feature, >=1).
- REPEAT_RATE, 100, ticks between subsequent auto-repeat pulses (used only with the optional feature, >=1).

Ports:
- CLOCK  input  1  system clock; all state updates on its rising edge.
- RESET_N  input  1  asynchronous, active-low reset.
- PUSHBUTTON  input  N_BTN  raw asynchronous button inputs, active-high.
- LEVEL  output  N_BTN  debounced button level.
- SINGLE_PULSE  output  N_BTN  one-CLOCK-cycle pulse on each debounced press (and on repeats, if enabled).
- RELEASE_PULSE  output  N_BTN  one-CLOCK-cycle pulse on each debounced release.
- SAMPLE_TICK  output  1  internal sample enable, exported for test; high one cycle every TICK_DIV cycles.

Behaviour:
- Reset: asynchronous on RESET_N low. Synchronisers, tick counter, per-channel counters, LEVEL, SINGLE_PULSE, RELEASE_PULSE and SAMPLE_TICK all go to 0. All channel FSMs enter LOW.
- Synchroniser: two flops per channel on CLOCK; the filter sees only the second-stage output (sync).
- Tick counter:
  - Counts 0..TICK_DIV-1 and wraps to 0; width is $clog2(TICK_DIV), minimum 1.
  - SAMPLE_TICK is high in the cycle the counter equals TICK_DIV-1.
  - With TICK_DIV=1, SAMPLE_TICK is high every cycle.
- Per-channel FSM: states LOW, CONFIRM_HIGH, HIGH, CONFIRM_LOW. Transitions are evaluated only on SAMPLE_TICK.
  - Each channel has a stable counter of width $clog2(STABLE_CNT+1).
  - LOW: sync=1 -> counter=1. If STABLE_CNT=1, go directly to HIGH; otherwise go to CONFIRM_HIGH.
  - CONFIRM_HIGH: sync=1 -> increment counter; on reaching STABLE_CNT go to HIGH. sync=0 -> counter=0, return to LOW.
  - HIGH and CONFIRM_LOW: mirror images of LOW and CONFIRM_HIGH with the sync polarity inverted.
- Outputs:
  - LEVEL is 1 in HIGH and CONFIRM_LOW, 0 otherwise. It is registered and changes in the cycle after the qualifying tick.
  - SINGLE_PULSE[i] is high for exactly the one cycle in which LEVEL[i] rises. RELEASE_PULSE[i] is high for exactly the one cycle in which LEVEL[i] falls.
  - No output changes between ticks except that pulses drop after one cycle.
- Latency: from a clean input edge to pulse = 2 sync cycles + wait to the next tick + (STABLE_CNT-1) ticks + 1 cycle. Maximum is STABLE_CNT*TICK_DIV + 3 cycles.
- Glitch rejection: an input that does not hold for STABLE_CNT consecutive ticks never changes LEVEL and never pulses.
- Channels are fully independent. Simultaneous qualifying changes on several channels pulse in the same cycle.
- Button held through reset release: LEVEL starts at 0, rises after STABLE_CNT ticks, and SINGLE_PULSE fires once.
- Reset mid-confirm: the partial count is discarded and no pulse is issued.

Optional Feature:
- Macro: DEBOUNCE_AUTOREPEAT_EN.
- Defined:
  - Each channel has a repeat tick counter, cleared on entry to HIGH.
  - While the channel is in HIGH or CONFIRM_LOW, SINGLE_PULSE re-fires for one cycle after REPEAT_DELAY ticks from the press pulse, then every REPEAT_RATE ticks.
  - Repeats stop on the cycle LEVEL falls. A repeat never coincides with a RELEASE_PULSE.
- Undefined: exactly one SINGLE_PULSE per press. REPEAT_DELAY and REPEAT_RATE are ignored and no repeat logic is synthesised.

Test Plan:
All scenarios use N_BTN=2, TICK_DIV=4, STABLE_CNT=3 unless stated.
1. Reset: RESET_N=0 with PUSHBUTTON=2'b11 -> LEVEL, SINGLE_PULSE, RELEASE_PULSE all 0. After release, LEVEL=2'b11 appears within 3*4+3=15 cycles, SINGLE_PULSE=2'b11 for exactly 1 cycle, and both pulse in the same cycle.
2. Clean press/hold/release on channel 0:
   - Press, hold 200 cycles -> exactly one SINGLE_PULSE[0], which coincides with the LEVEL[0] rise.
   - Release -> exactly one RELEASE_PULSE[0] within 15 cycles; LEVEL[0]=0.
3. Bounce on channel 1: toggle every 5 cycles for 60 cycles -> no pulse and LEVEL[1]=0. Then hold high -> one SINGLE_PULSE[1]. Channel 0 stays quiet throughout.
4. Reset mid-confirm: channel 0 high for 2 ticks, then RESET_N low for 3 cycles -> no pulse. After reset release with input still high, a full 3-tick confirm is needed before the pulse.
5. Boundary parameters TICK_DIV=1, STABLE_CNT=1: SAMPLE_TICK is high every cycle, and a 1-cycle input change (past the synchroniser) produces a pulse 4 cycles after the raw edge.
6. With DEBOUNCE_AUTOREPEAT_EN, REPEAT_DELAY=5, REPEAT_RATE=2, hold channel 0 for 40 ticks -> pulses at press, press+5 ticks, then every 2 ticks, with none after release. Without the macro -> exactly 1 pulse.
